// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes pushed into a small FIFO are sent
// LSB-first on tx, back-to-back with no idle gap while the FIFO has data.
module uart_tx_fifo #(
  parameter int DIV_RATE   = 260,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       tx_busy,
  output logic       tx_end,
  output logic       tx
);

  localparam int CNT_W = (DIV_RATE > 2) ? $clog2(DIV_RATE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV_RATE - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        idx_q;
  logic [7:0]        sh_q;
  logic              tx_q, tx_busy_q, tx_end_q, ovf_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic              bit_end, push, pop;

  assign full  = (count_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // full is judged on the pre-edge count, so a pop never frees room for a same-cycle push
  always_comb begin
    bit_end = (cnt_q == CNT_LAST);
    push    = wr_en & ~full;
    pop     = ~empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
    count_d = count_q;
    if (push & ~pop)
      count_d = count_q + 1'b1;
    else if (pop & ~push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_end_q  <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wptr_q] <= wr_data;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (wr_en & full)
        ovf_q <= 1'b1;
      if (pop) begin
        sh_q   <= mem_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      tx_end_q <= (state_q == STOP) && (cnt_q == CNT_PRE);
      cnt_q    <= ((state_q == IDLE) || bit_end) ? '0 : cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= START;
            tx_q      <= 1'b0;
            tx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              tx_q  <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q   <= IDLE;
              tx_busy_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign overflow = ovf_q;
  assign tx_busy  = tx_busy_q;
  assign tx_end   = tx_end_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed plus random bench for uart_tx_fifo against a frame-level line model
// and a mid-bit sampling receiver.
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx_busy, tx_end, tx;

  uart_tx_fifo #(.DIV_RATE(DIV), .FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow),
    .tx_busy(tx_busy), .tx_end(tx_end), .tx(tx)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int errs = 0;

  // reference model: queue of pending bytes plus position inside the current frame
  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];
  bit         m_busy = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 0;
  int         ends = 0;

  bit         rx_act = 0;
  int         rx_c = 0;
  logic [7:0] rx_b = 8'h00;
  logic       prev_tx = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic model_edge(input bit rst, input bit wr, input logic [7:0] d);
    int  pre_n;
    bit  pre_full;
    if (rst) begin
      mq.delete(); acc_q.delete(); rx_q.delete();
      m_busy = 0; m_pos = 0; m_ovf = 0;
      return;
    end
    pre_n    = mq.size();
    pre_full = (pre_n == DEPTH);
    if (!m_busy) begin
      if (pre_n > 0) begin
        m_cur = mq.pop_front(); m_busy = 1; m_pos = 0;
      end
    end else if (m_pos == FRAME - 1) begin
      if (pre_n > 0) begin
        m_cur = mq.pop_front(); m_pos = 0;
      end else m_busy = 0;
    end else m_pos++;
    if (wr) begin
      if (pre_full) m_ovf = 1;
      else begin mq.push_back(d); acc_q.push_back(d); end
    end
  endtask

  task automatic step(input bit rst, input bit wr, input logic [7:0] d);
    reset = rst; wr_en = wr; wr_data = d;
    @(posedge clk);
    model_edge(rst, wr, d);
    #1;
    chk("tx", tx, exp_tx());
    chk("tx_busy", tx_busy, m_busy);
    chk("tx_end", tx_end, m_busy && (m_pos == FRAME - 1));
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
    if (tx_end === 1'b1) ends++;
    if (rst) rx_act = 0;
    else if (!rx_act) begin
      if (prev_tx === 1'b1 && tx === 1'b0) begin rx_act = 1; rx_c = 0; end
    end else begin
      rx_c++;
      if (rx_c % DIV == DIV / 2 && rx_c / DIV >= 1 && rx_c / DIV <= 8)
        rx_b[rx_c / DIV - 1] = tx;
      if (rx_c == 9 * DIV + DIV / 2) begin
        if (tx === 1'b1) rx_q.push_back(rx_b);
        rx_act = 0;
      end
    end
    prev_tx = tx;
    reset = 1'b0; wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy || mq.size() != 0 || rx_act) && n < 2000) begin
      step(0, 0, 8'h00); n++;
    end
    chk("drain_bound", n < 2000, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00);
  endtask

  task automatic wait_pop_edge();
    int n = 0;
    while (!(m_busy && m_pos == FRAME - 1) && n < 200) begin
      step(0, 0, 8'h00); n++;
    end
    chk("wait_pop_bound", n < 200, 1);
  endtask

  initial begin
    int e0, n;

    // 1: single 0x55 frame
    step(1, 0, 8'h00);
    chk("reset_tx", tx, 1);
    chk("reset_empty", empty, 1);
    e0 = ends;
    step(0, 1, 8'h55);
    step(0, 0, 8'h00);
    chk("t1_start_low", tx, 0);
    drain();
    chk("t1_rx_n", rx_q.size(), 1);
    chk("t1_rx0", rx_q[0], 8'h55);
    chk("t1_ends", ends - e0, 1);
    chk("t1_idle_busy", tx_busy, 0);

    // 2: ABC back-to-back
    step(1, 0, 8'h00);
    e0 = ends;
    step(0, 1, 8'h41); step(0, 1, 8'h42); step(0, 1, 8'h43);
    drain();
    chk("t2_rx_n", rx_q.size(), 3);
    chk("t2_rx0", rx_q[0], 8'h41);
    chk("t2_rx1", rx_q[1], 8'h42);
    chk("t2_rx2", rx_q[2], 8'h43);
    chk("t2_ends", ends - e0, 3);

    // 3: five writes fill, sixth overflows
    step(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i));
    chk("t3_full", full, 1);
    chk("t3_no_ovf", overflow, 0);
    step(0, 1, 8'hEE);
    chk("t3_ovf", overflow, 1);
    drain();
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_rx_n", rx_q.size(), 5);
    chk("t3_rx4", rx_q[4], 8'h64);

    // 4: push on the pop edge while full is dropped; with 3 entries count holds
    step(1, 0, 8'h00);
    chk("t4_ovf_clear", overflow, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h10 + i));
    wait_pop_edge();
    step(0, 1, 8'h99);
    chk("t4_ovf", overflow, 1);
    chk("t4_full_after_pop", full, 0);
    wait_pop_edge();
    step(0, 1, 8'h77);
    chk("t4_cnt3_full", full, 0);
    chk("t4_cnt3_empty", empty, 0);
    drain();
    chk("t4_rx_n", rx_q.size(), 6);
    chk("t4_rx5", rx_q[5], 8'h77);

    // 5: reset during data bit 3 of 0xA5
    step(1, 0, 8'h00);
    e0 = ends;
    step(0, 1, 8'hA5);
    n = 0;
    while (!(m_busy && m_pos / DIV == 4) && n < 100) begin step(0, 0, 8'h00); n++; end
    chk("t5_wait_bound", n < 100, 1);
    step(1, 0, 8'h00);
    chk("t5_tx", tx, 1);
    chk("t5_busy", tx_busy, 0);
    chk("t5_empty", empty, 1);
    for (int i = 0; i < 60; i++) step(0, 0, 8'h00);
    chk("t5_ends", ends - e0, 0);
    chk("t5_rx_n", rx_q.size(), 0);

    // 6: all-zero then all-one byte
    step(1, 0, 8'h00);
    step(0, 1, 8'h00); step(0, 1, 8'hFF);
    drain();
    chk("t6_rx_n", rx_q.size(), 2);
    chk("t6_rx0", rx_q[0], 8'h00);
    chk("t6_rx1", rx_q[1], 8'hFF);

    // random traffic, including overflow drops
    step(1, 0, 8'h00);
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 9) == 0, 8'($urandom));
    drain();
    chk("rnd_rx_n", rx_q.size(), acc_q.size());
    for (int i = 0; i < acc_q.size() && i < rx_q.size(); i++)
      chk("rnd_rx_byte", rx_q[i], acc_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
